axi_sram_slave: RTL and testbench



---
 rtl/axi_pkg.sv | 41 ++++
 rtl/sram_1rw.sv | 32 +++
 rtl/axi_sram_slave.sv | 213 +++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI response/size constants, responder FSM state type, response decode helper
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] SIZE_B = 3'd0;
   localparam logic [2:0] SIZE_H = 3'd1;
   localparam logic [2:0] SIZE_W = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_RESP,
      ST_WR_WAIT,
      ST_WR_RESP
   } sram_state_e;

   // Window check wins over size/alignment/wlast checks; sizes above word count as misaligned.
   function automatic logic [1:0] resp_calc(input logic [31:0] addr, input logic [31:0] base,
                                            input logic [31:0] span, input logic [2:0] size,
                                            input logic last);
      logic [31:0] offset;
      logic        misaligned;
      offset = addr - base;
      case (size)
         SIZE_B:  misaligned = 1'b0;
         SIZE_H:  misaligned = addr[0];
         SIZE_W:  misaligned = (addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
      if (offset >= span)
         resp_calc = RESP_DECERR;
      else if (misaligned || !last)
         resp_calc = RESP_SLVERR;
      else
         resp_calc = RESP_OKAY;
   endfunction

endpackage

// File: rtl/sram_1rw.sv
// rtl/sram_1rw.sv - single-port 32-bit SRAM, synchronous read/write with byte enables
module sram_1rw #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < 4; b++) begin
               if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-beat AXI4 responder in front of a word-addressed SRAM
// Define AXI_SRAM_SLAVE_RAND_DELAY_EN for LFSR-driven extra latency and ready stalls.
module axi_sram_slave
   import axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0f00_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_LAT      = 1,
   parameter int          WR_LAT      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic [2:0]  arsize,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic [2:0]  awsize,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

   sram_state_e      state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [31:0]      awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [2:0]       awsize_q, awsize_d, arsize_q, arsize_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic             wlast_q, wlast_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       rresp_q, rresp_d, bresp_q, bresp_d;
   logic             rvalid_q, rvalid_d, bvalid_q, bvalid_d;
   logic             ready_gate, idle_rdy, ar_hs, aw_hs, w_hs, mem_we;
   logic [15:0]      extra_lat;
   logic [1:0]       rd_resp, wr_resp;
   logic [31:0]      sram_rdata;
   logic [IDX_W-1:0] sram_addr;

`ifdef AXI_SRAM_SLAVE_RAND_DELAY_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
   assign ready_gate = lfsr_q[3];
   assign extra_lat  = {13'd0, lfsr_q[2:0]};
`else
   assign ready_gate = 1'b1;
   assign extra_lat  = 16'd0;
`endif

   // Readies depend only on registered state; arready also yields to any write activity.
   assign idle_rdy = (state_q == ST_IDLE) & ~rst & ready_gate;
   assign awready  = idle_rdy & ~aw_held_q;
   assign wready   = idle_rdy & ~w_held_q;
   assign arready  = idle_rdy & ~aw_held_q & ~w_held_q & ~awvalid & ~wvalid;

   assign ar_hs = arvalid & arready;
   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;

   assign rd_resp = resp_calc(araddr_q, BASE_ADDR, SPAN, arsize_q, 1'b1);
   assign wr_resp = resp_calc(awaddr_q, BASE_ADDR, SPAN, awsize_q, wlast_q);

   // The SRAM read is launched on the AR handshake so its output is ready by the last wait cycle.
   assign sram_addr = mem_we ? IDX_W'((awaddr_q - BASE_ADDR) >> 2)
                             : IDX_W'((araddr - BASE_ADDR) >> 2);

   sram_1rw #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
      .clk_i   (clk),
      .en_i    (ar_hs | mem_we),
      .we_i    (mem_we),
      .be_i    (wstrb_q),
      .addr_i  (sram_addr),
      .wdata_i (wdata_q),
      .rdata_o (sram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      awsize_d  = awsize_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wlast_d   = wlast_q;
      araddr_d  = araddr_q;
      arsize_d  = arsize_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      bvalid_d  = bvalid_q;
      mem_we    = 1'b0;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         awaddr_d  = awaddr;
         awsize_d  = awsize;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = wdata;
         wstrb_d  = wstrb;
         wlast_d  = wlast;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (ar_hs) begin
               state_d  = ST_RD_WAIT;
               araddr_d = araddr;
               arsize_d = arsize;
               cnt_d    = 16'(RD_LAT - 1) + extra_lat;
            end else if (aw_held_d && w_held_d) begin
               state_d = ST_WR_WAIT;
               cnt_d   = 16'(WR_LAT - 1) + extra_lat;
            end
         end
         ST_RD_WAIT: begin
            if (cnt_q == '0) begin
               rresp_d  = rd_resp;
               rdata_d  = (rd_resp == RESP_OKAY) ? sram_rdata : 32'd0;
               rvalid_d = 1'b1;
               state_d  = ST_RD_RESP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_RD_RESP: begin
            if (rready) begin
               rvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         ST_WR_WAIT: begin
            if (cnt_q == '0) begin
               mem_we    = (wr_resp == RESP_OKAY) & ~rst;
               bresp_d   = wr_resp;
               bvalid_d  = 1'b1;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               state_d   = ST_WR_RESP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_WR_RESP: begin
            if (bready) begin
               bvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         bvalid_q  <= bvalid_d;
      end
      awaddr_q <= awaddr_d;
      awsize_q <= awsize_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wlast_q  <= wlast_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
   end

   assign rdata  = rdata_q;
   assign rresp  = rresp_q;
   assign rvalid = rvalid_q;
   assign bresp  = bresp_q;
   assign bvalid = bvalid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed self-checking bench for axi_sram_slave (RD_LAT=2, WR_LAT=4)
module tb_axi_sram_slave;

   localparam int RD_LAT = 2;
   localparam int WR_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, wlast;
   logic [3:0]  wstrb;
   logic [1:0]  rresp, bresp;
   logic        bvalid, bready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_sram_slave #(
      .BASE_ADDR   (32'h0f00_0000),
      .DEPTH_WORDS (1024),
      .RD_LAT      (RD_LAT),
      .WR_LAT      (WR_LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr),
      .arsize  (arsize),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awsize  (awsize),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wlast   (wlast),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // W is presented first; AW follows w_lead cycles later (0 = same cycle).
   task automatic write_txn(input string tag, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d, input logic [3:0] s, input logic last,
                            input int w_lead, input logic [1:0] exp_resp);
      bit aw_done, w_done, got;
      int cyc;
      aw_done = 0; w_done = 0; got = 0; cyc = 0;
      awaddr = a; awsize = sz; wdata = d; wstrb = s; wlast = last; bready = 1'b1;
      while (!got && cyc < 60) begin
         awvalid = !aw_done && (cyc >= w_lead);
         wvalid  = !w_done;
         #1;
         if (bvalid) begin
            got = 1;
            chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
         end
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         step();
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      chk({tag, "_bdone"}, 32'(got), 32'd1);
   endtask

   task automatic read_txn(input string tag, input logic [31:0] a, input logic [2:0] sz,
                           input int stall, input logic [31:0] exp_d, input logic [1:0] exp_resp);
      bit hs;
      int cyc, lat;
      hs = 0; cyc = 0; lat = 0;
      araddr = a; arsize = sz; arvalid = 1'b1; rready = 1'b0;
      while (!hs && cyc < 60) begin
         #1;
         hs = arready;
         step();
         cyc++;
      end
      arvalid = 1'b0;
      chk({tag, "_arhs"}, 32'(hs), 32'd1);
      while (!rvalid && lat < 60) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(RD_LAT));
      chk({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
      chk({tag, "_rdata"}, rdata, exp_d);
      repeat (stall) begin
         step();
         chk({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
         chk({tag, "_hold_rdata"}, rdata, exp_d);
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
      chk({tag, "_rdone"}, 32'(rvalid), 32'd0);
   endtask

   initial begin
      bit seen_b;
      int cyc;
      rst = 1'b1;
      araddr = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awsize = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
      wvalid = 1'b0; bready = 1'b0;
      repeat (3) step();
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      rst = 1'b0;
      step();
      chk("idle_arready", 32'(arready), 32'd1);
      chk("idle_awready", 32'(awready), 32'd1);
      chk("idle_wready", 32'(wready), 32'd1);
      chk("idle_rresp", 32'(rresp), 32'd0);
      chk("idle_bresp", 32'(bresp), 32'd0);
      chk("idle_rdata", rdata, 32'd0);

      write_txn("w_same", 32'h0f00_0010, 3'd2, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 2'b00);
      read_txn("r_same", 32'h0f00_0010, 3'd2, 0, 32'hDEAD_BEEF, 2'b00);
      write_txn("w_lead", 32'h0f00_0013, 3'd0, 32'hAB00_0000, 4'h8, 1'b1, 2, 2'b00);
      read_txn("r_lead", 32'h0f00_0010, 3'd2, 0, 32'hABAD_BEEF, 2'b00);
      read_txn("r_half", 32'h0f00_0012, 3'd1, 0, 32'hABAD_BEEF, 2'b00);

      read_txn("r_decerr", 32'h1000_0000, 3'd2, 0, 32'd0, 2'b11);
      read_txn("r_below", 32'h0eff_fffc, 3'd2, 0, 32'd0, 2'b11);
      read_txn("r_mis_h", 32'h0f00_0011, 3'd1, 0, 32'd0, 2'b10);
      read_txn("r_size3", 32'h0f00_0010, 3'd3, 0, 32'd0, 2'b10);

      write_txn("w_base", 32'h0f00_0000, 3'd2, 32'hCAFE_F00D, 4'hF, 1'b1, 0, 2'b00);
      write_txn("w_mis", 32'h0f00_0002, 3'd2, 32'h5555_5555, 4'hF, 1'b1, 0, 2'b10);
      write_txn("w_nolast", 32'h0f00_0000, 3'd2, 32'h6666_6666, 4'hF, 1'b0, 0, 2'b10);
      write_txn("w_nostrb", 32'h0f00_0000, 3'd2, 32'hFFFF_FFFF, 4'h0, 1'b1, 0, 2'b00);
      write_txn("w_top", 32'h0f00_0ffc, 3'd2, 32'h0BAD_F00D, 4'hF, 1'b1, 0, 2'b00);
      write_txn("w_past", 32'h0f00_1000, 3'd2, 32'h7777_7777, 4'hF, 1'b1, 0, 2'b11);
      read_txn("r_base", 32'h0f00_0000, 3'd2, 0, 32'hCAFE_F00D, 2'b00);
      read_txn("r_top", 32'h0f00_0ffc, 3'd2, 0, 32'h0BAD_F00D, 2'b00);
      read_txn("r_past", 32'h0f00_1000, 3'd2, 0, 32'd0, 2'b11);

      // R held off for five cycles while a write waits behind it
      araddr = 32'h0f00_0010; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
      #1;
      chk("stall_arready", 32'(arready), 32'd1);
      step();
      arvalid = 1'b0;
      awaddr = 32'h0f00_0020; awsize = 3'd2; wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1;
      awvalid = 1'b1; wvalid = 1'b1;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         chk("stall_rvalid", 32'(rvalid), 32'd1);
         chk("stall_rdata", rdata, 32'hABAD_BEEF);
         chk("stall_awready", 32'(awready), 32'd0);
         chk("stall_wready", 32'(wready), 32'd0);
         step();
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
      #1;
      chk("post_r_rvalid", 32'(rvalid), 32'd0);
      chk("post_r_awready", 32'(awready), 32'd1);
      chk("post_r_wready", 32'(wready), 32'd1);
      step();
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      cyc = 0;
      while (!bvalid && cyc < 60) begin
         step();
         cyc++;
      end
      chk("post_r_bvalid", 32'(bvalid), 32'd1);
      chk("post_r_bresp", 32'(bresp), 32'd0);
      step();
      bready = 1'b0;
      read_txn("stall_rb", 32'h0f00_0020, 3'd2, 0, 32'h1234_5678, 2'b00);
      read_txn("stall_r", 32'h0f00_0010, 3'd2, 5, 32'hABAD_BEEF, 2'b00);

      // Reset lands while the write is still counting down
      write_txn("w_old", 32'h0f00_0030, 3'd2, 32'h1111_1111, 4'hF, 1'b1, 0, 2'b00);
      awaddr = 32'h0f00_0030; awsize = 3'd2; wdata = 32'h2222_2222; wstrb = 4'hF; wlast = 1'b1;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      #1;
      chk("wrst_awready", 32'(awready), 32'd1);
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("wrst_bvalid", 32'(bvalid), 32'd0);
      chk("wrst_arready", 32'(arready), 32'd0);
      step();
      rst = 1'b0;
      seen_b = 0;
      repeat (8) begin
         step();
         seen_b |= bvalid;
      end
      bready = 1'b0;
      chk("wrst_no_b", 32'(seen_b), 32'd0);
      read_txn("wrst_rb", 32'h0f00_0030, 3'd2, 0, 32'h1111_1111, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
